vu_level_meter: RTL and testbench
=================================

// Module: vu_level_meter
// PURPOSE
//  Downstream consumer of the UART receiver. Takes received bytes (data/load/error) as offset-binary audio samples.
//  Computes the per-window peak magnitude and keeps a displayed level with instant attack, linear decay and peak-hold.
//  Drives the LED bar of the VU meter with a thermometer code plus a peak-hold dot.
// PARAMETERS
//  NUM_LEDS      8        bar length; power of 2, 2..128; STEP = 128/NUM_LEDS
//  WINDOW        64       good samples per peak window; >=2
//  DECAY_CYCLES  3125000  clk cycles per 1-LSB level decay step (100 ms at 31.25 MHz)
//  HOLD_CYCLES   31250000 clk cycles the peak-hold dot stays before falling back to level
// PORTS
//  clk          in   1         system clock, rising edge
//  reset        in   1         asynchronous, active-low (0 = reset)
//  data         in   8         sample byte from UART receiver, 0x80 = silence
//  load         in   1         1-cycle strobe: data valid
//  error        in   1         qualifies load: framing error, sample must be dropped
//  leds         out  NUM_LEDS  bar thermometer OR peak-hold dot
//  level        out  7         current displayed level, 0..127
//  sample_drop  out  1         1-cycle pulse per dropped (error) sample
// BEHAVIOUR
//  Reset (reset=0, async): win_max=0, win_cnt=0, level=0, hold=0, decay/hold timers=0, leds=0, sample_drop=0.
//  Good sample = load&!error. Bad sample = load&error -> sample_drop=1 next cycle; no other state changes.
//  mag = |data-128|, saturated to 127 (data 0x00 -> 127).
//  Window: each good sample sets win_max<=max(win_max,mag) and win_cnt+1.
//   On the good sample with win_cnt==WINDOW-1: commit peak=max(win_max,mag); win_max<=0; win_cnt<=0 (wrap).
//  Decay timer: free-running 0..DECAY_CYCLES-1; tick = terminal count.
//  Level update (registered, 1 cycle after commit sample):
//   commit & peak>=level -> level<=peak (attack wins over tick);
//   else tick & level>0 -> level<=level-1; else hold value. level never underflows.
//  Hold: if new level>hold -> hold<=level, hold timer reloads HOLD_CYCLES-1.
//   Else timer counts down; at 0, hold<=level (tracks level thereafter).
//  Bar (registered, 1 cycle after level/hold): leds[i] = (level > i*STEP) | dot[i].
//   dot = onehot((hold-1)/STEP) when hold>0, else 0.
//  Latency: window-closing load at cycle t -> level at t+1 -> leds at t+2.
//  load asserted on consecutive cycles is legal; every strobe is handled.
//  Reset mid-window discards the partial window.
// STRUCTURE
//  vu_pkg: SAMPLE_W=8, MAG_W=7, MIDPOINT=8'd128, function mag_sat(byte) -> 7-bit.
//  Sub-module vu_bar_decoder (level, hold -> leds, registered, parameter NUM_LEDS).
//  Top holds: window FSM/counters, decay timer, hold timer, level/hold registers.
// TESTING (WINDOW=4, DECAY_CYCLES=8, HOLD_CYCLES=16, NUM_LEDS=8, STEP=16)
//  1 reset=0 mid-stream with toggling load -> leds=0, level=0, sample_drop=0 immediately; win_cnt=0 after release.
//  2 good loads 0x80,0x90,0x70,0xF0 (mags 0,16,16,112) -> level=112 one cycle after 4th load; leds=8'h7F next cycle.
//  3 no further loads -> level decrements by 1 every 8 cycles to 0, never wraps.
//    hold stays 112 (dot led[6]) for 16 cycles, then follows level; leds end 8'h00.
//  4 load with error=1, data=0x00 -> sample_drop pulse 1 cycle; win_cnt, level, leds unchanged.
//  5 window of 0x00 x4 -> level=127, leds=8'hFF; 0x80 x4 -> no attack, decay continues.
//  6 window closes on a decay tick with peak<level -> level-1; with peak>=level -> level=peak.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared types, constants and helpers for the VU level meter.
// Samples are offset-binary bytes; magnitudes are 7-bit saturated.
package vu_pkg;

    localparam int SAMPLE_W = 8;
    localparam int MAG_W    = 7;

    localparam logic [SAMPLE_W-1:0] MIDPOINT = 8'd128;
    localparam logic [MAG_W-1:0]    MAG_MAX  = 7'd127;

    // |s - 128|, clipped to 127 (only s = 0x00 would reach 128).
    function automatic logic [MAG_W-1:0] mag_sat(
        input logic [SAMPLE_W-1:0] s
    );
        logic [SAMPLE_W-1:0] d;
        if (s >= MIDPOINT) begin
            d = s - MIDPOINT;
        end else begin
            d = MIDPOINT - s;
        end
        if (d[SAMPLE_W-1]) begin
            mag_sat = MAG_MAX;
        end else begin
            mag_sat = d[MAG_W-1:0];
        end
    endfunction

endpackage

// File: rtl/vu_bar_decoder.sv
// Registered LED bar: thermometer code of level OR a one-hot
// peak-hold dot. Ports: clk, reset (async low), level, hold -> leds.
import vu_pkg::*;

module vu_bar_decoder #(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MAG_W-1:0]    level,
    input  logic [MAG_W-1:0]    hold,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int STEP = 128 / NUM_LEDS;
    localparam int SH   = $clog2(STEP);

    logic [MAG_W-1:0]    hold_m1;
    logic [MAG_W-1:0]    dot_idx;
    logic [NUM_LEDS-1:0] dot;
    logic [NUM_LEDS-1:0] bar;

    // Dot sits on the LED whose band contains hold, i.e.
    // (hold-1)/STEP; STEP is a power of two so this is a shift.
    always_comb begin
        hold_m1 = hold - 7'd1;
        dot_idx = hold_m1 >> SH;
        dot     = '0;
        if (hold != '0) begin
            dot = NUM_LEDS'(1) << dot_idx;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_bar
        localparam logic [7:0] TH = 8'(i * STEP);
        assign bar[i] = ({1'b0, level} > TH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds <= '0;
        end else begin
            leds <= bar | dot;
        end
    end

endmodule

// File: rtl/vu_level_meter.sv
// VU meter: windowed peak of UART audio bytes, attack/decay level,
// peak-hold dot. Ports: clk, reset (async low), data/load/error in;
// leds (bar), level (0..127), sample_drop (bad-byte pulse) out.
import vu_pkg::*;

module vu_level_meter #(
    parameter int NUM_LEDS     = 8,
    parameter int WINDOW       = 64,
    parameter int DECAY_CYCLES = 3125000,
    parameter int HOLD_CYCLES  = 31250000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          data,
    input  logic                load,
    input  logic                error,
    output logic [NUM_LEDS-1:0] leds,
    output logic [6:0]          level,
    output logic                sample_drop
);

    localparam int WC_W = $clog2(WINDOW);
    localparam int DC_W = $clog2(DECAY_CYCLES + 1);
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WINDOW - 1);
    localparam logic [DC_W-1:0] DEC_LAST  = DC_W'(DECAY_CYCLES - 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    logic              good;
    logic              bad;
    logic [MAG_W-1:0]  mag;
    logic [MAG_W-1:0]  run_max;
    logic              win_close;
    logic              tick;

    logic [MAG_W-1:0]  win_max;
    logic [WC_W-1:0]   win_cnt;
    logic [DC_W-1:0]   dec_cnt;
    logic [HC_W-1:0]   hold_tmr;
    logic [MAG_W-1:0]  hold;
    logic [MAG_W-1:0]  level_nxt;

    always_comb begin
        good      = load & ~error;
        bad       = load & error;
        mag       = mag_sat(data);
        run_max   = (mag > win_max) ? mag : win_max;
        win_close = good && (win_cnt == WIN_LAST);
        tick      = (dec_cnt == DEC_LAST);
    end

    // Attack beats decay: a closing window whose peak reaches the
    // current level wins even on a tick cycle.
    always_comb begin
        level_nxt = level;
        if (win_close && (run_max >= level)) begin
            level_nxt = run_max;
        end else if (tick && (level != '0)) begin
            level_nxt = level - 7'd1;
        end
    end

    // Window accumulator: bad samples leave it untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_max <= '0;
            win_cnt <= '0;
        end else if (good) begin
            if (win_close) begin
                win_max <= '0;
                win_cnt <= '0;
            end else begin
                win_max <= run_max;
                win_cnt <= win_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dec_cnt <= '0;
        end else if (tick) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level       <= '0;
            sample_drop <= 1'b0;
        end else begin
            level       <= level_nxt;
            sample_drop <= bad;
        end
    end

    // Hold rises with level and freezes for HOLD_CYCLES; once the
    // timer has run out it simply follows level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold     <= '0;
            hold_tmr <= '0;
        end else if (level_nxt > hold) begin
            hold     <= level_nxt;
            hold_tmr <= HOLD_LAST;
        end else if (hold_tmr == '0) begin
            hold     <= level_nxt;
        end else begin
            hold_tmr <= hold_tmr - 1'b1;
        end
    end

    vu_bar_decoder #(
        .NUM_LEDS (NUM_LEDS)
    ) u_bar (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .hold  (hold),
        .leds  (leds)
    );

endmodule

// File: tb/tb_vu_level_meter.sv
// Self-checking bench for vu_level_meter with a behavioural model
// driven from sample queues and absolute cycle stamps.
module tb_vu_level_meter;

    localparam int NL   = 8;
    localparam int WIN  = 4;
    localparam int DEC  = 8;
    localparam int HLD  = 16;
    localparam int STEP = 128 / NL;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    data = 8'h80;
    logic          load = 1'b0;
    logic          error = 1'b0;
    logic [NL-1:0] leds;
    logic [6:0]    level;
    logic          sample_drop;

    int errors = 0;
    int checks = 0;

    int      m_q[$];
    int      m_level;
    int      m_hold;
    int      m_hold_until;
    int      m_e;
    logic [NL-1:0] m_leds;
    logic    m_drop;

    vu_level_meter #(
        .NUM_LEDS     (NL),
        .WINDOW       (WIN),
        .DECAY_CYCLES (DEC),
        .HOLD_CYCLES  (HLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .load        (load),
        .error       (error),
        .leds        (leds),
        .level       (level),
        .sample_drop (sample_drop)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input int d);
        if (d >= 128) return d - 128;
        return (128 - d > 127) ? 127 : 128 - d;
    endfunction

    function automatic logic [NL-1:0] bar_of(input int lv, input int hd);
        logic [NL-1:0] b;
        for (int i = 0; i < NL; i++) begin
            b[i] = (lv > i * STEP) || (hd > 0 && (hd - 1) / STEP == i);
        end
        return b;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_level = 0;
        m_hold = 0;
        m_hold_until = 0;
        m_e = 0;
        m_leds = '0;
        m_drop = 1'b0;
    endtask

    task automatic model_step();
        bit tick;
        bit commit;
        int peak;
        int nl;
        if (!reset) begin
            model_reset();
            return;
        end
        tick = (m_e % DEC) == DEC - 1;
        m_e++;
        m_leds = bar_of(m_level, m_hold);
        m_drop = load && error;
        commit = 0;
        peak = 0;
        if (load && !error) begin
            m_q.push_back(mag_of(int'(data)));
            if (m_q.size() == WIN) begin
                commit = 1;
                foreach (m_q[k]) if (m_q[k] > peak) peak = m_q[k];
                m_q.delete();
            end
        end
        nl = m_level;
        if (commit && peak >= m_level) nl = peak;
        else if (tick && m_level > 0) nl = m_level - 1;
        if (nl > m_hold) begin
            m_hold = nl;
            m_hold_until = m_e + HLD;
        end else if (m_e >= m_hold_until) begin
            m_hold = nl;
        end
        m_level = nl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        load = 1'b0;
        error = 1'b0;
        data = 8'h80;
        model_reset();
        cycle();
        cycle();
        reset = 1'b1;
    endtask

    task automatic drive(input logic l, input logic e, input logic [7:0] d);
        load = l;
        error = e;
        data = d;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h00);
            cycle();
        end
        drive(1, 0, 8'hF0);
        cycle();
        cycle();
        drive(1, 1, 8'h12);
        cycle();
        drive(1, 0, 8'hF0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks += 3;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL rst_leds: got %h want 00", leds);
        end
        if (level !== 7'd0) begin
            errors++;
            $display("FAIL rst_level: got %0d want 0", level);
        end
        if (sample_drop !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop: got %b want 0", sample_drop);
        end
        for (int i = 0; i < 4; i++) begin
            drive(~load, 0, 8'hF0);
            cycle();
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 8'hF0);
            cycle();
        end
        drive(0, 0, 8'h80);
        cycle();
        cycle();
        checks++;
        if (level !== 7'd0) begin
            errors++;
            $display("FAIL rst_window: got %0d want 0", level);
        end
        do_reset();
    endtask

    task automatic test_attack();
        logic [7:0] seq [4] = '{8'h80, 8'h90, 8'h70, 8'hF0};
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, seq[i]);
            cycle();
        end
        drive(0, 0, 8'h80);
        checks++;
        if (level !== 7'd112) begin
            errors++;
            $display("FAIL attack_level: got %0d want 112", level);
        end
        cycle();
        checks++;
        if (leds !== 8'h7F) begin
            errors++;
            $display("FAIL attack_leds: got %h want 7f", leds);
        end
    endtask

    task automatic test_decay();
        for (int i = 0; i < 1000; i++) begin
            cycle();
            checks += 2;
            if (level !== 7'(m_level) || level > 7'd112) begin
                errors++;
                $display("FAIL decay_level: got %0d want %0d", level, m_level);
            end
            if (leds !== m_leds) begin
                errors++;
                $display("FAIL decay_leds: got %h want %h", leds, m_leds);
            end
        end
        checks += 2;
        if (level !== 7'd0) begin
            errors++;
            $display("FAIL decay_end_level: got %0d want 0", level);
        end
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL decay_end_leds: got %h want 00", leds);
        end
    endtask

    task automatic test_error();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 8'h90);
            cycle();
        end
        drive(1, 1, 8'h00);
        cycle();
        drive(0, 0, 8'h80);
        checks += 2;
        if (sample_drop !== 1'b1) begin
            errors++;
            $display("FAIL err_drop: got %b want 1", sample_drop);
        end
        if (level !== 7'd0) begin
            errors++;
            $display("FAIL err_level: got %0d want 0", level);
        end
        cycle();
        checks += 2;
        if (sample_drop !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got %b want 0", sample_drop);
        end
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL err_leds: got %h want 00", leds);
        end
        drive(1, 0, 8'hA0);
        cycle();
        drive(0, 0, 8'h80);
        checks++;
        if (level !== 7'd32) begin
            errors++;
            $display("FAIL err_window: got %0d want 32", level);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h00);
            cycle();
        end
        drive(0, 0, 8'h80);
        checks++;
        if (level !== 7'd127) begin
            errors++;
            $display("FAIL full_level: got %0d want 127", level);
        end
        cycle();
        checks++;
        if (leds !== 8'hFF) begin
            errors++;
            $display("FAIL full_leds: got %h want ff", leds);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h80);
            cycle();
            checks += 2;
            if (level !== 7'(m_level)) begin
                errors++;
                $display("FAIL silent_level: got %0d want %0d", level, m_level);
            end
            if (leds !== m_leds) begin
                errors++;
                $display("FAIL silent_leds: got %h want %h", leds, m_leds);
            end
        end
        drive(0, 0, 8'h80);
    endtask

    task automatic test_tick_commit();
        int prev;
        logic [7:0] last [2] = '{8'h90, 8'hFF};
        int want;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1, 0, (s == 0) ? 8'h90 : 8'h80);
                cycle();
            end
            drive(0, 0, 8'h80);
            for (int k = 0; k < DEC && (m_e % DEC) != DEC - 1; k++) cycle();
            checks++;
            if ((m_e % DEC) != DEC - 1) begin
                errors++;
                $display("FAIL tick_align: got %0d want %0d", m_e % DEC, DEC - 1);
            end
            prev = int'(level);
            want = (s == 0) ? prev - 1 : 127;
            drive(1, 0, last[s]);
            cycle();
            drive(0, 0, 8'h80);
            checks += 2;
            if (level !== 7'(want)) begin
                errors++;
                $display("FAIL tick_commit%0d: got %0d want %0d", s, level, want);
            end
            if (level !== 7'(m_level)) begin
                errors++;
                $display("FAIL tick_model%0d: got %0d want %0d", s, level, m_level);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            drive(1, 0, 8'($urandom));
            cycle();
            checks += 2;
            if (level !== 7'(m_level)) begin
                errors++;
                $display("FAIL b2b_level: got %0d want %0d", level, m_level);
            end
            if (leds !== m_leds) begin
                errors++;
                $display("FAIL b2b_leds: got %h want %h", leds, m_leds);
            end
        end
        drive(0, 0, 8'h80);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  8'($urandom));
            cycle();
            checks += 3;
            if (level !== 7'(m_level)) begin
                errors++;
                $display("FAIL rnd_level: got %0d want %0d", level, m_level);
            end
            if (leds !== m_leds) begin
                errors++;
                $display("FAIL rnd_leds: got %h want %h", leds, m_leds);
            end
            if (sample_drop !== m_drop) begin
                errors++;
                $display("FAIL rnd_drop: got %b want %b", sample_drop, m_drop);
            end
        end
        drive(0, 0, 8'h80);
    endtask

    initial begin
        model_reset();
        #3;
        test_reset();
        test_attack();
        test_decay();
        test_error();
        test_full();
        test_tick_commit();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
